// File: rtl/cb_cfg_pkg.sv
// Shared types and helpers for the cb_cfg_chain connection block.
// Optional feature macro: CB_CFG_PARITY_EN (adds an even-parity bit to the chain).
package cb_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } cfg_state_e;

  // Ceiling log2, returns 0 for v <= 1
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Active config width: one select field per CLB pin plus two steering bits per track
  function automatic int unsigned cfg_len(input int unsigned track_w, input int unsigned clb_in);
    return clb_in * clog2(2 * track_w) + 2 * track_w;
  endfunction

  // Steering bit for sb_feed_out[k]
  function automatic int unsigned sb_bit(input int unsigned k);
    return 2 * k;
  endfunction

  // Steering bit for track_out[k]
  function automatic int unsigned trk_bit(input int unsigned k);
    return 2 * k + 1;
  endfunction

  // LSB of the select field for CLB pin i
  function automatic int unsigned sel_lsb(input int unsigned track_w, input int unsigned sel_w,
                                          input int unsigned i);
    return 2 * track_w + i * sel_w;
  endfunction

endpackage

// File: rtl/cb_cfg_chain_route_mux.sv
// Pool-to-pin selector; selects beyond the pool width yield 0.
module cb_route_mux
  import cb_cfg_pkg::*;
#(
  parameter int unsigned POOL_W = 8,
  parameter int unsigned SEL_W  = 3
) (
  input  logic [POOL_W-1:0] pool,
  input  logic [SEL_W-1:0]  sel,
  output logic              y
);

  // Out-of-range selects (non-power-of-2 pool) drive 0
  always_comb begin
    y = 1'b0;
    if (32'(sel) < POOL_W) y = pool[sel];
  end

endmodule

// File: rtl/cb_cfg_chain.sv
// Parametrised connection block with serial shadow config chain and atomic commit.
// Optional feature macro: CB_CFG_PARITY_EN (chain gains an even-parity bit checked on commit).
module cb_cfg_chain
  import cb_cfg_pkg::*;
#(
  parameter int unsigned TRACK_W = 4,
  parameter int unsigned CLB_IN  = 4
) (
  input  logic               prog_clk,
  input  logic               prog_rst_n,
  input  logic               prog_in,
  input  logic               prog_en,
  input  logic               prog_commit,
  output logic               prog_out,
  output logic               cfg_valid,
  output logic               cfg_err,
  input  logic [TRACK_W-1:0] track_in_a,
  input  logic [TRACK_W-1:0] track_in_b,
  input  logic [TRACK_W-1:0] sb_feed_in,
  input  logic               clb_out,
  output logic [CLB_IN-1:0]  clb_in,
  output logic [TRACK_W-1:0] track_out,
  output logic [TRACK_W-1:0] sb_feed_out
);

  localparam int unsigned POOL_W   = 2 * TRACK_W;
  localparam int unsigned SEL_W    = clog2(POOL_W);
  localparam int unsigned CFG_BITS = cfg_len(TRACK_W, CLB_IN);
`ifdef CB_CFG_PARITY_EN
  localparam int unsigned CHAIN_LEN = CFG_BITS + 1;
`else
  localparam int unsigned CHAIN_LEN = CFG_BITS;
`endif
  localparam int unsigned CNT_W = clog2(CHAIN_LEN + 1);

  cfg_state_e           state, state_nxt;
  logic [CNT_W-1:0]     count, count_nxt;
  logic [CHAIN_LEN-1:0] shadow, shadow_nxt;
  logic [CFG_BITS-1:0]  active, active_nxt;
  logic                 valid_nxt, err_nxt;
  logic                 parity_ok;
  logic [POOL_W-1:0]    pool;
  logic [CLB_IN-1:0]    pick;

  // Parity gate on commit (always passes without the parity feature)
`ifdef CB_CFG_PARITY_EN
  assign parity_ok = (shadow[CFG_BITS] == ^shadow[CFG_BITS-1:0]);
`else
  assign parity_ok = 1'b1;
`endif

  // State and config registers with synchronous active-low reset
  always_ff @(posedge prog_clk) begin
    if (!prog_rst_n) begin
      state     <= IDLE;
      count     <= '0;
      shadow    <= '0;
      active    <= '0;
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      shadow    <= shadow_nxt;
      active    <= active_nxt;
      cfg_valid <= valid_nxt;
      cfg_err   <= err_nxt;
    end
  end

  // Next-state: commit has priority over shift and drops prog_in
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    shadow_nxt = shadow;
    active_nxt = active;
    valid_nxt  = cfg_valid;
    err_nxt    = cfg_err;
    if (prog_commit) begin
      if (state == FULL && parity_ok) begin
        active_nxt = shadow[CFG_BITS-1:0];
        valid_nxt  = 1'b1;
        err_nxt    = 1'b0;
        count_nxt  = '0;
        state_nxt  = IDLE;
      end else begin
        err_nxt = 1'b1;
      end
    end else if (prog_en) begin
      shadow_nxt = {prog_in, shadow[CHAIN_LEN-1:1]};
      if (count != CNT_W'(CHAIN_LEN)) count_nxt = count + CNT_W'(1);
      case (state)
        IDLE, LOAD: state_nxt = (count_nxt == CNT_W'(CHAIN_LEN)) ? FULL : LOAD;
        FULL:       state_nxt = FULL;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  // Shadow bit 0 is the daisy-chain output
  assign prog_out = shadow[0];

  // Interleave the two track buses into the select pool
  always_comb begin
    pool = '0;
    for (int unsigned k = 0; k < TRACK_W; k++) begin
      pool[2*k]   = track_in_a[k];
      pool[2*k+1] = track_in_b[k];
    end
  end

  for (genvar i = 0; i < CLB_IN; i++) begin : g_pin
    cb_route_mux #(
      .POOL_W(POOL_W),
      .SEL_W (SEL_W)
    ) u_mux (
      .pool(pool),
      .sel (active[sel_lsb(TRACK_W, SEL_W, i) +: SEL_W]),
      .y   (pick[i])
    );
  end

  // Track steering, all routing forced low until a config is active
  always_comb begin
    clb_in      = '0;
    track_out   = '0;
    sb_feed_out = '0;
    if (cfg_valid) begin
      clb_in = pick;
      for (int unsigned k = 0; k < TRACK_W; k++) begin
        sb_feed_out[k] = active[sb_bit(k)] ? track_in_b[k] : clb_out;
        track_out[k]   = active[trk_bit(k)] ? clb_out : sb_feed_in[k];
      end
    end
  end

endmodule

// File: tb/tb_cb_cfg_chain.sv
// Self-checking bench for cb_cfg_chain against a queue-based reference model.
// Honours CB_CFG_PARITY_EN the same way as the design.
module tb_cb_cfg_chain;

  localparam int unsigned TRACK_W  = 4;
  localparam int unsigned CLB_IN   = 4;
  localparam int unsigned SEL_W    = 3;
  localparam int unsigned CFG_BITS = 20;
`ifdef CB_CFG_PARITY_EN
  localparam int unsigned CHAIN_LEN = CFG_BITS + 1;
`else
  localparam int unsigned CHAIN_LEN = CFG_BITS;
`endif

  logic               prog_clk = 1'b0;
  logic               prog_rst_n = 1'b0;
  logic               prog_in = 1'b0;
  logic               prog_en = 1'b0;
  logic               prog_commit = 1'b0;
  logic               prog_out;
  logic               cfg_valid;
  logic               cfg_err;
  logic [TRACK_W-1:0] track_in_a = '0;
  logic [TRACK_W-1:0] track_in_b = '0;
  logic [TRACK_W-1:0] sb_feed_in = '0;
  logic               clb_out = 1'b0;
  logic [CLB_IN-1:0]  clb_in;
  logic [TRACK_W-1:0] track_out;
  logic [TRACK_W-1:0] sb_feed_out;

  int checks = 0;
  int errors = 0;

  // Reference model: shadow as a bit queue (index 0 = oldest = chain output)
  bit            sq[$];
  int            cnt;
  bit [19:0]     m_active;
  bit            m_valid;
  bit            m_err;

  cb_cfg_chain #(.TRACK_W(TRACK_W), .CLB_IN(CLB_IN)) dut (
    .prog_clk   (prog_clk),
    .prog_rst_n (prog_rst_n),
    .prog_in    (prog_in),
    .prog_en    (prog_en),
    .prog_commit(prog_commit),
    .prog_out   (prog_out),
    .cfg_valid  (cfg_valid),
    .cfg_err    (cfg_err),
    .track_in_a (track_in_a),
    .track_in_b (track_in_b),
    .sb_feed_in (sb_feed_in),
    .clb_out    (clb_out),
    .clb_in     (clb_in),
    .track_out  (track_out),
    .sb_feed_out(sb_feed_out)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_parity_ok();
`ifdef CB_CFG_PARITY_EN
    bit p;
    p = 1'b0;
    for (int i = 0; i < int'(CFG_BITS); i++) p ^= sq[i];
    return p == sq[CFG_BITS];
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_edge(input bit rst_v, input bit en_v, input bit com_v, input bit in_v);
    if (!rst_v) begin
      sq.delete();
      for (int i = 0; i < int'(CHAIN_LEN); i++) sq.push_back(1'b0);
      cnt = 0; m_active = '0; m_valid = 0; m_err = 0;
    end else if (com_v) begin
      if (cnt == int'(CHAIN_LEN) && model_parity_ok()) begin
        for (int i = 0; i < int'(CFG_BITS); i++) m_active[i] = sq[i];
        m_valid = 1; m_err = 0; cnt = 0;
      end else begin
        m_err = 1;
      end
    end else if (en_v) begin
      void'(sq.pop_front());
      sq.push_back(in_v);
      if (cnt < int'(CHAIN_LEN)) cnt++;
    end
  endtask

  // Apply routing inputs and compare all routed outputs against the active model
  task automatic chk_route(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sb,
                           input logic co);
    logic [3:0] ec, et, es;
    logic [2:0] s;
    track_in_a = a; track_in_b = b; sb_feed_in = sb; clb_out = co;
    #1;
    ec = '0; et = '0; es = '0;
    if (m_valid) begin
      for (int k = 0; k < 4; k++) begin
        es[k] = m_active[2*k]   ? b[k] : co;
        et[k] = m_active[2*k+1] ? co   : sb[k];
      end
      for (int i = 0; i < 4; i++) begin
        s = m_active[8 + 3*i +: 3];
        ec[i] = s[0] ? b[s >> 1] : a[s >> 1];
      end
    end
    chk("clb_in", 32'(clb_in), 32'(ec));
    chk("track_out", 32'(track_out), 32'(et));
    chk("sb_feed_out", 32'(sb_feed_out), 32'(es));
  endtask

  task automatic step(input bit rst_v, input bit en_v, input bit com_v, input bit in_v);
    prog_rst_n = rst_v; prog_en = en_v; prog_commit = com_v; prog_in = in_v;
    @(posedge prog_clk);
    #1;
    model_edge(rst_v, en_v, com_v, in_v);
    prog_rst_n = 1'b1; prog_en = 1'b0; prog_commit = 1'b0; prog_in = 1'b0;
    chk("prog_out", 32'(prog_out), 32'(sq[0]));
    chk("cfg_valid", 32'(cfg_valid), 32'(m_valid));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
    chk_route(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
  endtask

  task automatic shift_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, w[i]);
  endtask

  // Append the correct parity bit when the chain carries one
  function automatic logic [31:0] with_parity(input logic [19:0] c);
`ifdef CB_CFG_PARITY_EN
    return {11'd0, ^c, c};
`else
    return {12'd0, c};
`endif
  endfunction

  initial begin
    logic [19:0] cfg1;
    logic [31:0] w;
    int r;

    // Reset: everything low whatever the inputs
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk_route(4'hF, 4'hF, 4'hF, 1'b1);

    // Directed load: sel3..0 = 7,0,1,2, low byte AA
    cfg1 = {3'd7, 3'd0, 3'd1, 3'd2, 8'hAA};
    shift_bits(with_parity(cfg1), int'(CHAIN_LEN));
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk_route(4'h5, 4'h0, 4'h0, 1'b1);
    chk_route(4'hA, 4'hF, 4'h3, 1'b0);

    // Short load rejected, completed load accepted
    step(1'b0, 1'b0, 1'b0, 1'b0);
    w = with_parity(20'($urandom));
    shift_bits(w, 12);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    shift_bits(w >> 12, int'(CHAIN_LEN) - 12);
    step(1'b1, 1'b0, 1'b1, 1'b0);

    // Overlong load: surplus bits stream out of prog_out
    shift_bits(32'($urandom), int'(CHAIN_LEN) + 5);
    step(1'b1, 1'b0, 1'b1, 1'b0);

    // Shift and commit together: commit wins, shadow kept, count cleared
    shift_bits(with_parity(20'($urandom)), int'(CHAIN_LEN));
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    shift_bits(32'($urandom), int'(CHAIN_LEN));
    step(1'b1, 1'b0, 1'b1, 1'b0);

    // Reset mid-load, then a clean load
    shift_bits(32'($urandom), 10);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    shift_bits(with_parity(20'($urandom)), int'(CHAIN_LEN));
    step(1'b1, 1'b0, 1'b1, 1'b0);

`ifdef CB_CFG_PARITY_EN
    // Wrong parity rejected, correct parity then accepted
    w = with_parity(20'($urandom));
    w[20] = ~w[20];
    shift_bits(w, int'(CHAIN_LEN));
    step(1'b1, 1'b0, 1'b1, 1'b0);
    shift_bits(with_parity(20'($urandom)), int'(CHAIN_LEN));
    step(1'b1, 1'b0, 1'b1, 1'b0);
`endif

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2)       step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
      else if (r < 8)  step(1'b1, 1'b0, 1'b1, 1'($urandom));
      else if (r < 10) step(1'b1, 1'b1, 1'b1, 1'($urandom));
      else if (r < 85) step(1'b1, 1'b1, 1'b0, 1'($urandom));
      else             step(1'b1, 1'b0, 1'b0, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
